// File: rtl/cfu_mac_pkg.sv
// Shared opcodes, FSM state type and width helpers for the SIMD MAC custom function unit.
package cfu_mac_pkg;

  localparam logic [6:0] OP_MAC          = 7'd0;
  localparam logic [6:0] OP_CLEAR        = 7'd1;
  localparam logic [6:0] OP_SET_IN_OFF   = 7'd2;
  localparam logic [6:0] OP_SET_FILT_OFF = 7'd3;
  localparam logic [6:0] OP_READ         = 7'd4;
  localparam logic [6:0] OP_SET_ACC      = 7'd5;
  localparam logic [6:0] OP_READ_OFF     = 7'd6;
  localparam logic [6:0] OP_STATUS       = 7'd7;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Lane product is (LANE_W+2)x(LANE_W+2); the reduction grows by log2(lanes).
  function automatic int dot_sum_w(input int lanes, input int lane_w);
    return 2 * lane_w + 4 + $clog2(lanes);
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/simd_dot_lanes.sv
// Combinational LANES-wide dot product of offset-adjusted signed lane operands.
module simd_dot_lanes
  import cfu_mac_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int LANE_W = 8
) (
  input  logic [LANES-1:0][LANE_W-1:0]              a,
  input  logic [LANES-1:0][LANE_W-1:0]              b,
  input  logic signed [LANE_W:0]                    in_off,
  input  logic signed [LANE_W:0]                    filt_off,
  output logic signed [dot_sum_w(LANES, LANE_W)-1:0] sum
);

  localparam int OS_W   = LANE_W + 2;
  localparam int PROD_W = 2 * LANE_W + 4;
  localparam int SUM_W  = dot_sum_w(LANES, LANE_W);

  logic signed [PROD_W-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [OS_W-1:0] a_os, b_os;
    assign a_os    = OS_W'($signed(a[i])) + OS_W'(in_off);
    assign b_os    = OS_W'($signed(b[i])) + OS_W'(filt_off);
    assign prod[i] = PROD_W'(a_os) * PROD_W'(b_os);
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < LANES; i++) sum = sum + SUM_W'(prod[i]);
  end

endmodule

// File: rtl/cfu_simd_mac_acc.sv
// SIMD MAC CFU: offset dot product into banked accumulators, fixed 2-cycle command-to-response.
module cfu_simd_mac_acc
  import cfu_mac_pkg::*;
#(
  parameter int LANES      = 4,
  parameter int LANE_W     = 8,
  parameter int NUM_ACC    = 4,
  parameter int ACC_W      = 32,
  parameter int IN_OFF_RST = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0
);

  localparam int SUM_W = dot_sum_w(LANES, LANE_W);
  localparam int SEL_W = sel_w(NUM_ACC);

  state_t                  state;
  logic [6:0]              op_q;
  logic [SEL_W-1:0]        sel_q;
  logic [31:0]             in0_q;
  logic signed [SUM_W-1:0] dot_sum, dot_q;
  logic [ACC_W-1:0]        acc [NUM_ACC];
  logic [NUM_ACC-1:0]      ovf;
  logic signed [LANE_W:0]  in_off, filt_off;

  logic [SEL_W-1:0] cmd_sel;
  logic [ACC_W-1:0] acc_sel, addend, mac_sum;
  logic             mac_ovf;

  simd_dot_lanes #(.LANES(LANES), .LANE_W(LANE_W)) u_dot (
    .a        (cmd_payload_inputs_0),
    .b        (cmd_payload_inputs_1),
    .in_off   (in_off),
    .filt_off (filt_off),
    .sum      (dot_sum)
  );

  function automatic logic [31:0] acc32(input logic [ACC_W-1:0] v);
    return 32'($signed(v));
  endfunction

  assign cmd_ready = (state == IDLE);
  assign cmd_sel   = SEL_W'(cmd_payload_function_id[2:0] & 3'(NUM_ACC - 1));

  // Overflow: operands agree in sign but the wrapped sum does not.
  always_comb begin
    acc_sel = acc[sel_q];
    addend  = ACC_W'(dot_q);
    mac_sum = acc_sel + addend;
    mac_ovf = (acc_sel[ACC_W-1] == addend[ACC_W-1]) && (mac_sum[ACC_W-1] != acc_sel[ACC_W-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= IDLE;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      op_q                  <= '0;
      sel_q                 <= '0;
      in0_q                 <= '0;
      dot_q                 <= '0;
      ovf                   <= '0;
      in_off                <= (LANE_W+1)'(IN_OFF_RST);
      filt_off              <= '0;
      for (int k = 0; k < NUM_ACC; k++) acc[k] <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op_q  <= cmd_payload_function_id[9:3];
          sel_q <= cmd_sel;
          in0_q <= cmd_payload_inputs_0;
          dot_q <= dot_sum;
          state <= EXEC;
        end
        EXEC: begin
          rsp_payload_outputs_0 <= '0;
          case (op_q)
            OP_MAC: begin
              acc[sel_q]            <= mac_sum;
              if (mac_ovf) ovf[sel_q] <= 1'b1;
              rsp_payload_outputs_0 <= acc32(mac_sum);
            end
            OP_CLEAR: begin
              acc[sel_q]            <= '0;
              ovf[sel_q]            <= 1'b0;
              rsp_payload_outputs_0 <= acc32(acc_sel);
            end
            OP_SET_IN_OFF:   in_off   <= in0_q[LANE_W:0];
            OP_SET_FILT_OFF: filt_off <= in0_q[LANE_W:0];
            OP_READ:         rsp_payload_outputs_0 <= acc32(acc_sel);
            OP_SET_ACC: begin
              acc[sel_q]            <= in0_q[ACC_W-1:0];
              ovf[sel_q]            <= 1'b0;
              rsp_payload_outputs_0 <= acc32(in0_q[ACC_W-1:0]);
            end
            OP_READ_OFF:     rsp_payload_outputs_0 <= {16'(filt_off), 16'(in_off)};
            OP_STATUS:       rsp_payload_outputs_0 <= 32'(ovf);
            default: ;
          endcase
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cfu_simd_mac_acc.md
Name: cfu_simd_mac_acc

Overview:
- Parametrised successor to the single-accumulator SIMD MAC custom function unit on the CPU's CFU bus.
- Computes a LANES-wide dot product with programmable input and filter offsets.
- Accumulates into one of NUM_ACC banked accumulators with sticky signed-overflow flags.
- Uniform 2-cycle command-to-response latency, controlled by a small state machine.

Parameters:
- LANES, 4, number of SIMD lanes; LANES*LANE_W must equal 32.
- LANE_W, 8, signed operand width per lane.
- NUM_ACC, 4, number of accumulators (power of 2, 1..8); selected by function_id[2:0] modulo NUM_ACC.
- ACC_W, 32, accumulator width (16..32); responses are sign-extended to 32.
- IN_OFF_RST, 128, reset value of the input offset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  unit can accept a command
- cmd_payload_function_id  in  10  [9:3]=op (funct7), [2:0]=accumulator select
- cmd_payload_inputs_0  in  32  packed lane operands A / scalar argument
- cmd_payload_inputs_1  in  32  packed lane operands B
- rsp_valid  out  1  response valid
- rsp_ready  in  1  CPU accepts response
- rsp_payload_outputs_0  out  32  result

Behaviour:
- Reset: state=IDLE; rsp_valid=0; rsp_payload_outputs_0=0; all acc=0; all ovf=0; in_off=IN_OFF_RST; filt_off=0.
- Reset mid-operation discards any in-flight command; no response is produced for it.
- State machine:
  - IDLE: cmd_ready=1. Accept on cmd_valid. Latch op, sel, inputs, and the registered lane-product sum. Go to EXEC.
  - EXEC: perform the state update. Load rsp_payload_outputs_0. Go to RESP.
  - RESP: rsp_valid=1. Hold the payload stable until rsp_ready=1, then return to IDLE.
- cmd_ready is 1 only in IDLE, so at most one command is in flight.
- Latency: accepted at cycle T -> rsp_valid=1 at T+2. Next accept is possible at the cycle after the handshake. Minimum 3 cycles per command.
- Lane math:
  - a_i = signed inputs_0 lane i; b_i = signed inputs_1 lane i.
  - Operands are (a_i + in_off) * (b_i + filt_off).
  - Offsets are signed, LANE_W+1 bits. Offset sums are LANE_W+2 bits. Products are 2*LANE_W+4 bits.
  - Lane sum adds clog2(LANES) bits, then is sign-extended to ACC_W. No truncation occurs before accumulation.
- Ops (funct7):
  - 0 MAC: acc[sel] += sum, modulo 2^ACC_W. Signed overflow of this add sets ovf[sel] (sticky). Returns the new acc[sel].
  - 1 CLEAR: acc[sel]=0, ovf[sel]=0. Returns the old acc[sel].
  - 2 SET_IN_OFF: in_off = inputs_0[LANE_W:0]. Returns 0.
  - 3 SET_FILT_OFF: filt_off = inputs_0[LANE_W:0]. Returns 0.
  - 4 READ: returns acc[sel]; no state change.
  - 5 SET_ACC: acc[sel] = inputs_0[ACC_W-1:0], ovf[sel]=0. Returns the value written.
  - 6 READ_OFF: returns {sext16(filt_off), sext16(in_off)}.
  - 7 STATUS: returns ovf bits zero-extended (bit k = ovf[k]).
  - Any other op: no state change; returns 0.
- Accumulator responses are sign-extended from ACC_W to 32.
- cmd_valid in a non-IDLE state is ignored; the payload is not sampled.
- rsp_ready while rsp_valid=0 has no effect.

Decomposition:
- Shared package cfu_mac_pkg holds:
  - op-code localparams (OP_MAC..OP_STATUS);
  - the state enum (IDLE/EXEC/RESP);
  - width helper functions.
- One sub-module, simd_dot_lanes: purely combinational; LANES-wide offset-multiply-reduce; parametrised by LANES, LANE_W.
- The banked accumulator file and FSM stay in the top level.

Test Plan:
- Reset, then MAC sel=0 with inputs_0=0x01020304, inputs_1=0x01010101 -> rsp 522 (0x20A) at T+2; a second identical MAC -> 1044.
- SET_IN_OFF with inputs_0=0x1FF, then READ_OFF -> 0x0000FFFF. Then MAC sel=1 with inputs_0=0x02020202, inputs_1=0xFFFFFFFF -> rsp 0xFFFFFFFC (-4); acc0 is unchanged (READ sel=0 -> 0x20A).
- SET_ACC sel=2 with 0x7FFFFFF0; MAC with 0x7F7F7F7F/0x7F7F7F7F (in_off=128) -> 0x8001F9F4; STATUS -> 0x4; CLEAR sel=2 -> returns 0x8001F9F4, then STATUS -> 0x0.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and payload stay stable, cmd_ready=0 with cmd_valid held high, no second accept; the handshake releases and the next command is accepted the following cycle.
- Assert reset while in EXEC -> next cycle rsp_valid=0, cmd_ready=1; READ sel=0 -> 0; READ_OFF -> 0x00000080.
- Unknown op 9 -> rsp 0; a subsequent READ of all accumulators is unchanged.
